// File: rtl/gamepad_evt_pkg.sv
// Shared constants and types for the gamepad event unit.
// Button indices, event kind codes and scan FSM states.
package gamepad_evt_pkg;

  localparam int NBTN       = 12;
  localparam int BTN_R      = 0;
  localparam int BTN_L      = 1;
  localparam int BTN_X      = 2;
  localparam int BTN_A      = 3;
  localparam int BTN_RIGHT  = 4;
  localparam int BTN_LEFT   = 5;
  localparam int BTN_DOWN   = 6;
  localparam int BTN_UP     = 7;
  localparam int BTN_START  = 8;
  localparam int BTN_SELECT = 9;
  localparam int BTN_Y      = 10;
  localparam int BTN_B      = 11;
  localparam int DPAD_LO    = 4;
  localparam int DPAD_HI    = 7;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_REPEAT  = 2'b11
  } evt_kind_e;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } scan_state_e;

  typedef struct packed {
    evt_kind_e  kind;
    logic [3:0] idx;
  } evt_t;

endpackage

// File: rtl/gamepad_event_unit_if.sv
// Event stream handshake between the gamepad event unit and its consumer.
// Only carries traffic when GAMEPAD_EVT_FIFO_EN is defined.
interface gamepad_event_unit_if;
  logic       evt_valid;
  logic [5:0] evt_data;
  logic       evt_ready;
  logic       evt_overflow;

  modport master (
    output evt_valid,
    output evt_data,
    output evt_overflow,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_data,
    input  evt_overflow,
    output evt_ready
  );
endinterface

// File: rtl/gamepad_evt_fifo.sv
// 4-entry event FIFO with valid/ready pop and sticky overflow.
// A push while full is accepted only if the head pops the same cycle.
module gamepad_evt_fifo
  import gamepad_evt_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  evt_t push_data,
  input  logic pop_ready,
  output logic valid,
  output evt_t data,
  output logic overflow
);

  evt_t       mem_q [4];
  evt_t       mem_d [4];
  logic [1:0] wr_q, wr_d;
  logic [1:0] rd_q, rd_d;
  logic [2:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;
  logic       pop, do_push;

  always_comb begin
    pop     = (cnt_q != 3'd0) && pop_ready;
    do_push = push && ((cnt_q != 3'd4) || pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    ovf_d   = ovf_q | (push & ~do_push);
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 2'd1;
    end
    if (pop) rd_d = rd_q + 2'd1;
    cnt_d = cnt_q + {2'b00, do_push} - {2'b00, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign valid    = cnt_q != 3'd0;
  assign data     = mem_q[rd_q];
  assign overflow = ovf_q;

endmodule

// File: rtl/gamepad_event_unit.sv
// Frame-rate debounce, press/release and D-pad auto-repeat for 12 buttons.
// Optional event FIFO enabled by defining GAMEPAD_EVT_FIFO_EN.
module gamepad_event_unit
  import gamepad_evt_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_RATE     = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_tick,
  input  logic                 is_present,
  input  logic [11:0]          btn_raw,
  output logic [11:0]          btn_state,
  output logic [11:0]          press_pulse,
  output logic [11:0]          release_pulse,
  output logic [11:0]          repeat_pulse,
  output logic                 tick_overrun,
  gamepad_event_unit_if.master evt
);

  localparam logic [2:0] DEB   = 3'(DEBOUNCE_FRAMES);
  localparam logic [7:0] RDLY  = 8'(REPEAT_DELAY);
  localparam logic [7:0] RRATE = 8'(REPEAT_RATE);

  scan_state_e state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [11:0] snap_q, snap_d;
  logic        pres_q, pres_d;
  logic [2:0]  stab_q [12];
  logic [2:0]  stab_d [12];
  logic [7:0]  rep_q [4];
  logic [7:0]  rep_d [4];
  logic [11:0] pst_q, pst_d, ppr_q, ppr_d;
  logic [11:0] prl_q, prl_d, prp_q, prp_d;
  logic [11:0] st_q, st_d, pr_q, pr_d;
  logic [11:0] rl_q, rl_d, rp_q, rp_d;
  logic        ovr_q, ovr_d;

  logic        raw_b, lvl_b, acc, rise, fall, rpt, is_dpad;
  logic [1:0]  dp;
  logic [2:0]  stab_nx;
  logic [7:0]  rep_cur, rep_nx;
  logic        push;
  evt_t        push_data;
  evt_kind_e   kind;

  // Per-button datapath for the button currently under scan
  always_comb begin
    raw_b   = snap_q[idx_q];
    lvl_b   = st_q[idx_q];
    stab_nx = 3'd0;
    acc     = 1'b0;
    if (!pres_q) begin
      acc = lvl_b;
    end else if (raw_b != lvl_b) begin
      stab_nx = (stab_q[idx_q] == 3'd7) ? 3'd7 : stab_q[idx_q] + 3'd1;
      if (stab_nx >= DEB) begin
        acc     = 1'b1;
        stab_nx = 3'd0;
      end
    end
    rise    = acc & ~lvl_b;
    fall    = acc & lvl_b;
    is_dpad = (idx_q >= 4'(DPAD_LO)) && (idx_q <= 4'(DPAD_HI));
    dp      = idx_q[1:0];
    rep_cur = rep_q[dp];
    rep_nx  = rep_cur;
    rpt     = 1'b0;
    if (is_dpad) begin
      if (rise) begin
        rep_nx = RDLY;
      end else if (fall || !lvl_b) begin
        rep_nx = 8'd0;
      end else if (rep_cur <= 8'd1) begin
        rpt    = 1'b1;
        rep_nx = RRATE;
      end else begin
        rep_nx = rep_cur - 8'd1;
      end
    end
    kind = rise ? EVT_PRESS : (fall ? EVT_RELEASE : EVT_REPEAT);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    pres_d    = pres_q;
    stab_d    = stab_q;
    rep_d     = rep_q;
    pst_d     = pst_q;
    ppr_d     = ppr_q;
    prl_d     = prl_q;
    prp_d     = prp_q;
    st_d      = st_q;
    pr_d      = pr_q;
    rl_d      = rl_q;
    rp_d      = rp_q;
    ovr_d     = ovr_q;
    push      = 1'b0;
    push_data = '{kind: EVT_NONE, idx: 4'd0};
    unique case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d = SCAN;
          idx_d   = 4'd0;
          snap_d  = is_present ? btn_raw : 12'd0;
          pres_d  = is_present;
          pst_d   = '0;
          ppr_d   = '0;
          prl_d   = '0;
          prp_d   = '0;
        end
      end
      SCAN: begin
        ovr_d         = ovr_q | frame_tick;
        stab_d[idx_q] = stab_nx;
        if (is_dpad) rep_d[dp] = rep_nx;
        pst_d[idx_q]  = lvl_b ^ acc;
        ppr_d[idx_q]  = rise;
        prl_d[idx_q]  = fall;
        prp_d[idx_q]  = rpt;
        push          = rise | fall | rpt;
        push_data     = '{kind: kind, idx: idx_q};
        // The last button lands directly in the outputs, visible in COMMIT
        if (idx_q == 4'd11) begin
          state_d = COMMIT;
          st_d    = pst_d;
          pr_d    = ppr_d;
          rl_d    = prl_d;
          rp_d    = prp_d;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      COMMIT: begin
        ovr_d   = ovr_q | frame_tick;
        state_d = IDLE;
        pr_d    = '0;
        rl_d    = '0;
        rp_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      pres_q  <= 1'b0;
      stab_q  <= '{default: '0};
      rep_q   <= '{default: '0};
      pst_q   <= '0;
      ppr_q   <= '0;
      prl_q   <= '0;
      prp_q   <= '0;
      st_q    <= '0;
      pr_q    <= '0;
      rl_q    <= '0;
      rp_q    <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      pres_q  <= pres_d;
      stab_q  <= stab_d;
      rep_q   <= rep_d;
      pst_q   <= pst_d;
      ppr_q   <= ppr_d;
      prl_q   <= prl_d;
      prp_q   <= prp_d;
      st_q    <= st_d;
      pr_q    <= pr_d;
      rl_q    <= rl_d;
      rp_q    <= rp_d;
      ovr_q   <= ovr_d;
    end
  end

  assign btn_state     = st_q;
  assign press_pulse   = pr_q;
  assign release_pulse = rl_q;
  assign repeat_pulse  = rp_q;
  assign tick_overrun  = ovr_q;

`ifdef GAMEPAD_EVT_FIFO_EN
  evt_t fifo_data;

  gamepad_evt_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop_ready (evt.evt_ready),
    .valid     (evt.evt_valid),
    .data      (fifo_data),
    .overflow  (evt.evt_overflow)
  );

  assign evt.evt_data = fifo_data;
`else
  logic unused_evt;

  assign unused_evt       = ^{evt.evt_ready, push, push_data};
  assign evt.evt_valid    = 1'b0;
  assign evt.evt_data     = 6'd0;
  assign evt.evt_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_gamepad_event_unit.sv
// Randomized bench for gamepad_event_unit against a frame-level model.
// Define GAMEPAD_EVT_FIFO_EN to also exercise the event FIFO.
module tb_gamepad_event_unit;

  localparam int DEB  = 2;
  localparam int DLY  = 20;
  localparam int RATE = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        is_present = 1'b1;
  logic [11:0] btn_raw = '0;
  logic [11:0] btn_state, press_pulse, release_pulse, repeat_pulse;
  logic        tick_overrun;

  gamepad_event_unit_if evt_if ();

  gamepad_event_unit #(
    .DEBOUNCE_FRAMES (DEB),
    .REPEAT_DELAY    (DLY),
    .REPEAT_RATE     (RATE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .is_present    (is_present),
    .btn_raw       (btn_raw),
    .btn_state     (btn_state),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse),
    .tick_overrun  (tick_overrun),
    .evt           (evt_if)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int          m_lvl [12];
  int          m_run [12];
  int          m_held [12];
  logic [11:0] exp_st, exp_pr, exp_rl, exp_rp;
  logic [5:0]  exp_q [$];
  logic [11:0] last_st, last_pr, last_rl, last_rp;
  bit          fifo_chk = 1'b1;

  task automatic model_reset();
    for (int i = 0; i < 12; i++) begin
      m_lvl[i]  = 0;
      m_run[i]  = 0;
      m_held[i] = 0;
    end
    exp_st = '0;
  endtask

  // One frame of behaviour: counts consecutive differing samples and
  // frames held since press; repeats at DLY, DLY+RATE, DLY+2*RATE ...
  task automatic model_frame(input logic [11:0] raw, input logic pres);
    exp_pr = '0;
    exp_rl = '0;
    exp_rp = '0;
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      if (!pres) begin
        if (m_lvl[i] == 1) exp_rl[i] = 1'b1;
        m_lvl[i]  = 0;
        m_run[i]  = 0;
        m_held[i] = 0;
      end else begin
        if (int'(raw[i]) != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] >= DEB) begin
            m_run[i] = 0;
            if (m_lvl[i] == 1) exp_rl[i] = 1'b1;
            else exp_pr[i] = 1'b1;
            m_lvl[i]  = 1 - m_lvl[i];
            m_held[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        if (i >= 4 && i <= 7 && m_lvl[i] == 1 && !exp_pr[i]) begin
          m_held[i]++;
          if (m_held[i] >= DLY && (m_held[i] - DLY) % RATE == 0)
            exp_rp[i] = 1'b1;
        end
      end
      exp_st[i] = (m_lvl[i] != 0);
      if (exp_pr[i]) exp_q.push_back({2'b01, 4'(i)});
      else if (exp_rl[i]) exp_q.push_back({2'b10, 4'(i)});
      else if (exp_rp[i]) exp_q.push_back({2'b11, 4'(i)});
    end
  endtask

  task automatic run_frame(input logic [11:0] raw, input logic pres);
    logic [5:0] got [$];
    btn_raw    = raw;
    is_present = pres;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    btn_raw    = 12'($urandom);
    is_present = 1'($urandom);
    model_frame(raw, pres);
    for (int s = 1; s <= 13; s++) begin
      @(posedge clk); #1;
`ifdef GAMEPAD_EVT_FIFO_EN
      if (evt_if.evt_valid && evt_if.evt_ready) got.push_back(evt_if.evt_data);
`endif
      if (s == 12) begin
        last_st = btn_state;
        last_pr = press_pulse;
        last_rl = release_pulse;
        last_rp = repeat_pulse;
        n_chk++;
        if (btn_state !== exp_st)
          $display("FAIL btn_state: got %h exp %h", btn_state, exp_st);
        else n_pass++;
        n_chk++;
        if (press_pulse !== exp_pr)
          $display("FAIL press_pulse: got %h exp %h", press_pulse, exp_pr);
        else n_pass++;
        n_chk++;
        if (release_pulse !== exp_rl)
          $display("FAIL release_pulse: got %h exp %h", release_pulse, exp_rl);
        else n_pass++;
        n_chk++;
        if (repeat_pulse !== exp_rp)
          $display("FAIL repeat_pulse: got %h exp %h", repeat_pulse, exp_rp);
        else n_pass++;
      end else if (s == 6 || s == 13) begin
        n_chk++;
        if ({press_pulse, release_pulse, repeat_pulse} !== 36'd0)
          $display("FAIL pulse_idle s%0d: got %h/%h/%h exp 0",
                   s, press_pulse, release_pulse, repeat_pulse);
        else n_pass++;
      end
    end
`ifdef GAMEPAD_EVT_FIFO_EN
    if (fifo_chk) begin
      n_chk++;
      if (got.size() != exp_q.size())
        $display("FAIL evt_count: got %0d exp %0d", got.size(), exp_q.size());
      else begin
        n_pass++;
        for (int k = 0; k < got.size(); k++) begin
          n_chk++;
          if (got[k] !== exp_q[k])
            $display("FAIL evt_data[%0d]: got %b exp %b", k, got[k], exp_q[k]);
          else n_pass++;
        end
      end
    end
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({btn_state, press_pulse, release_pulse, repeat_pulse, tick_overrun,
         evt_if.evt_valid, evt_if.evt_overflow} !== 51'd0)
      $display("FAIL reset_outputs: got %h/%h/%h/%h ovr=%b v=%b of=%b exp 0",
               btn_state, press_pulse, release_pulse, repeat_pulse,
               tick_overrun, evt_if.evt_valid, evt_if.evt_overflow);
    else n_pass++;
  endtask

  task automatic test_debounce();
    run_frame(12'h080, 1'b1);
    run_frame(12'h080, 1'b1);
    n_chk++;
    if (last_pr !== 12'h080 || last_st[7] !== 1'b1)
      $display("FAIL up_press: got pr=%h st=%h exp pr=080 st[7]=1", last_pr, last_st);
    else n_pass++;
    run_frame(12'h000, 1'b1);
    run_frame(12'h000, 1'b1);
  endtask

  task automatic test_glitch();
    run_frame(12'h008, 1'b1);
    run_frame(12'h000, 1'b1);
    run_frame(12'h000, 1'b1);
    n_chk++;
    if (last_st[3] !== 1'b0)
      $display("FAIL glitch_a: got st[3]=%b exp 0", last_st[3]);
    else n_pass++;
  endtask

  task automatic test_repeat();
    int rep_f [$];
    int rel_f [$];
    for (int f = 0; f < 41; f++) begin
      run_frame((f < 36) ? 12'h020 : 12'h000, 1'b1);
      if (last_rp[5]) rep_f.push_back(f);
      if (last_rl[5]) rel_f.push_back(f);
    end
    n_chk++;
    if (rep_f.size() != 3 || rep_f[0] != 21 || rep_f[1] != 27 || rep_f[2] != 33)
      $display("FAIL left_repeat: got %0d pulses %p exp frames 21,27,33",
               rep_f.size(), rep_f);
    else n_pass++;
    n_chk++;
    if (rel_f.size() != 1 || rel_f[0] != 37)
      $display("FAIL left_release: got %p exp frame 37", rel_f);
    else n_pass++;
  endtask

  task automatic test_present_drop();
    run_frame(12'h108, 1'b1);
    run_frame(12'h108, 1'b1);
    run_frame(12'h108, 1'b0);
    n_chk++;
    if (last_rl !== 12'h108 || last_st !== 12'h000)
      $display("FAIL present_drop: got rl=%h st=%h exp rl=108 st=000", last_rl, last_st);
    else n_pass++;
  endtask

  task automatic test_overrun();
    btn_raw    = 12'h001;
    is_present = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    model_frame(12'h001, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_chk++;
    if (tick_overrun !== 1'b1)
      $display("FAIL overrun_set: got %b exp 1", tick_overrun);
    else n_pass++;
    run_frame(12'h001, 1'b1);
    n_chk++;
    if (tick_overrun !== 1'b1)
      $display("FAIL overrun_sticky: got %b exp 1", tick_overrun);
    else n_pass++;
    // Abort a scan that would have produced a press
    run_frame(12'h003, 1'b1);
    btn_raw    = 12'h003;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    repeat (5) @(posedge clk);
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({btn_state, press_pulse, release_pulse, tick_overrun} !== 37'd0)
        $display("FAIL midscan_reset c%0d: got st=%h pr=%h rl=%h ovr=%b exp 0",
                 c, btn_state, press_pulse, release_pulse, tick_overrun);
      else n_pass++;
    end
    run_frame(12'h002, 1'b1);
    run_frame(12'h002, 1'b1);
  endtask

  task automatic test_random();
    logic [11:0] tgt;
    logic [11:0] raw;
    logic        pres;
    tgt = '0;
    for (int f = 0; f < 90; f++) begin
      if ($urandom_range(2) == 0) tgt[$urandom_range(11)] ^= 1'b1;
      if ($urandom_range(4) == 0) tgt[$urandom_range(7, 4)] = 1'b1;
      raw  = tgt;
      if ($urandom_range(3) == 0) raw[$urandom_range(11)] ^= 1'b1;
      pres = ($urandom_range(24) != 0);
      run_frame(raw, pres);
    end
  endtask

  task automatic test_fifo();
`ifdef GAMEPAD_EVT_FIFO_EN
    do_reset();
    evt_if.evt_ready = 1'b0;
    fifo_chk = 1'b0;
    run_frame(12'h30F, 1'b1);
    run_frame(12'h30F, 1'b1);
    n_chk++;
    if (evt_if.evt_overflow !== 1'b1 || evt_if.evt_valid !== 1'b1)
      $display("FAIL fifo_overflow: got of=%b v=%b exp 1/1",
               evt_if.evt_overflow, evt_if.evt_valid);
    else n_pass++;
    evt_if.evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== {2'b01, 4'(k)})
        $display("FAIL fifo_pop[%0d]: got v=%b d=%b exp v=1 d=%b",
                 k, evt_if.evt_valid, evt_if.evt_data, {2'b01, 4'(k)});
      else n_pass++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (evt_if.evt_valid !== 1'b0)
      $display("FAIL fifo_drained: got v=%b exp 0", evt_if.evt_valid);
    else n_pass++;
    do_reset();
    fifo_chk = 1'b1;
    run_frame(12'h30F, 1'b1);
    run_frame(12'h30F, 1'b1);
    n_chk++;
    if (evt_if.evt_overflow !== 1'b0)
      $display("FAIL fifo_no_drop: got of=%b exp 0", evt_if.evt_overflow);
    else n_pass++;
`else
    evt_if.evt_ready = 1'b1;
    run_frame(12'h30F, 1'b1);
    run_frame(12'h30F, 1'b1);
    n_chk++;
    if ({evt_if.evt_valid, evt_if.evt_data, evt_if.evt_overflow} !== 8'd0)
      $display("FAIL evt_tieoff: got v=%b d=%b of=%b exp 0",
               evt_if.evt_valid, evt_if.evt_data, evt_if.evt_overflow);
    else n_pass++;
`endif
  endtask

  initial begin
    evt_if.evt_ready = 1'b1;
    model_reset();
    test_reset();
    test_debounce();
    test_glitch();
    test_repeat();
    test_present_drop();
    test_overrun();
    test_random();
    test_fifo();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
